// File: rtl/cartoon_pkg.sv
// Shared encodings for the cartoon video stage: mode codes and channel slots
// within a packed pixel (channel c occupies bits [c*CW +: CW]).
package cartoon_pkg;

  typedef enum logic [1:0] {
    MODE_BYPASS  = 2'd0,
    MODE_CARTOON = 2'd1,
    MODE_EDGE    = 2'd2,
    MODE_POSTER  = 2'd3
  } mode_e;

  localparam int CH_V = 0;
  localparam int CH_S = 1;

endpackage

// File: rtl/cartoon_pipe_sat_add_shift.sv
// Saturation boost: (s << SH) + OFS, clamped to the channel maximum.
// Purely combinational; the sum is kept wide enough that it never wraps.
module sat_add_shift #(
  parameter int CW  = 8,
  parameter int SH  = 1,
  parameter int OFS = 50
) (
  input  logic [CW-1:0] s,
  output logic [CW-1:0] sat
);

  localparam int SUM_W = CW + SH + 1;

  logic [SUM_W-1:0] sum;

  assign sum = (SUM_W'(s) << SH) + SUM_W'(OFS);
  // Any bit above the channel width means the result exceeded 2^CW-1.
  assign sat = (|sum[SUM_W-1:CW]) ? {CW{1'b1}} : sum[CW-1:0];

endmodule

// File: rtl/cartoon_pipe.sv
// Two-stage stallable cartoon filter: S1 registers inputs plus edge/saturation
// decisions, S2 forms the output pixel in the mode each pixel carried in with.
module cartoon_pipe
  import cartoon_pkg::*;
#(
  parameter int CW        = 8,
  parameter int NCH       = 3,
  parameter int SW        = 24,
  parameter int SAT_SH    = 1,
  parameter int SAT_OFS   = 50,
  parameter int POST_BITS = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sof,
  input  logic [NCH*CW-1:0] in_pixel,
  input  logic [NCH*CW-1:0] in_blur,
  input  logic [CW-1:0]     in_edge,
  input  logic [SW-1:0]     in_side,
  input  logic [CW-1:0]     edge_th,
  input  logic [1:0]        mode_req,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic [NCH*CW-1:0] out_pixel,
  output logic [SW-1:0]     out_side,
  output logic [1:0]        mode_active
);

  localparam int            PW        = NCH * CW;
  localparam logic [CW-1:0] CH_MAX    = {CW{1'b1}};
  localparam logic [CW-1:0] POST_MASK = CH_MAX << (CW - POST_BITS);

  mode_e           mode_q;
  mode_e           pix_mode;
  logic            s2_load;
  logic            in_fire;
  logic [CW-1:0]   sat_s;

  logic            s1_valid;
  logic            s1_sof;
  mode_e           s1_mode;
  logic            s1_edge;
  logic [CW-1:0]   s1_sat;
  logic [PW-1:0]   s1_pixel;
  logic [PW-1:0]   s1_blur;
  logic [SW-1:0]   s1_side;

  logic            s2_valid;
  logic [PW-1:0]   s2_next;

  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s2_load);
  assign in_fire  = in_valid && in_ready;
  assign pix_mode = in_sof ? mode_e'(mode_req) : mode_q;

  sat_add_shift #(
    .CW (CW),
    .SH (SAT_SH),
    .OFS(SAT_OFS)
  ) u_sat (
    .s  (in_blur[CH_S*CW +: CW]),
    .sat(sat_s)
  );

  // The frame mode only moves on an accepted sof, so stalls never tear a frame.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) begin
      mode_q <= MODE_BYPASS;
    end else if (in_fire && in_sof) begin
      mode_q <= mode_e'(mode_req);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: S1 payload has no reset; s1_valid alone qualifies it, which keeps
  // the wide data path free of reset fan-out.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_sof   <= in_sof;
      s1_mode  <= pix_mode;
      s1_edge  <= (in_edge > edge_th);
      s1_sat   <= sat_s;
      s1_pixel <= in_pixel;
      s1_blur  <= in_blur;
      s1_side  <= in_side;
    end
  end

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves s2_next
    // unassigned, which would otherwise infer a latch.
    s2_next = s1_blur;
    case (s1_mode)
      MODE_BYPASS: s2_next = s1_pixel;
      MODE_CARTOON: begin
        if (s1_edge) s2_next[CH_V*CW +: CW] = '0;
        else         s2_next[CH_S*CW +: CW] = s1_sat;
      end
      MODE_EDGE: begin
        s2_next                 = '0;
        s2_next[CH_V*CW +: CW]  = s1_edge ? '0 : CH_MAX;
      end
      MODE_POSTER: begin
        for (int c = 0; c < NCH; c++) begin
          s2_next[c*CW +: CW] = s1_blur[c*CW +: CW] & POST_MASK;
        end
        if (s1_edge) s2_next[CH_V*CW +: CW] = '0;
      end
      default: s2_next = s1_pixel;
    endcase
  end

  // Output registers are cleared so downstream sees zeros after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      out_sof   <= 1'b0;
      out_pixel <= '0;
      out_side  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_sof   <= s1_sof;
        out_pixel <= s2_next;
        out_side  <= s1_side;
      end
    end
  end

  assign out_valid   = s2_valid;
  assign mode_active = mode_q;

endmodule

// File: tb/tb_cartoon_pipe.sv
// Bench for cartoon_pipe: fixed vectors, hand-written corner sequences and a
// randomized backpressure run against an arithmetic reference model.
module tb_cartoon_pipe;

  localparam int CW        = 8;
  localparam int NCH       = 3;
  localparam int SW        = 24;
  localparam int SAT_SH    = 1;
  localparam int SAT_OFS   = 50;
  localparam int POST_BITS = 3;
  localparam int PW        = NCH * CW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sof = 1'b0;
  logic [PW-1:0] in_pixel = '0;
  logic [PW-1:0] in_blur = '0;
  logic [CW-1:0] in_edge = '0;
  logic [SW-1:0] in_side = '0;
  logic [CW-1:0] edge_th = '0;
  logic [1:0]    mode_req = 2'd0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          out_sof;
  logic [PW-1:0] out_pixel;
  logic [SW-1:0] out_side;
  logic [1:0]    mode_active;

  cartoon_pipe #(
    .CW(CW), .NCH(NCH), .SW(SW), .SAT_SH(SAT_SH), .SAT_OFS(SAT_OFS), .POST_BITS(POST_BITS)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_pixel(in_pixel), .in_blur(in_blur), .in_edge(in_edge), .in_side(in_side),
    .edge_th(edge_th), .mode_req(mode_req), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_pixel(out_pixel), .out_side(out_side), .mode_active(mode_active)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          sof;
    logic [SW-1:0] side;
    logic [PW-1:0] pix;
  } exp_t;

  typedef struct {
    logic [1:0]    mode;
    logic [PW-1:0] pixel;
    logic [PW-1:0] blur;
    logic [CW-1:0] edg;
    logic [CW-1:0] th;
    logic [PW-1:0] exp;
  } vec_t;

  int            checks = 0;
  int            errors = 0;
  int            bp_mode = 1;      // 0: out_ready low, 1: high, 2: random
  int            cyc = 0;
  logic [SW-1:0] side_tag = 24'h000100;
  exp_t          exp_q[$];
  logic [1:0]    model_mode = 2'd0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference: each channel treated as an integer and rebuilt from the rules.
  function automatic logic [PW-1:0] ref_pix(input logic [1:0] mode, input logic [PW-1:0] pix,
                                            input logic [PW-1:0] blur, input int e, input int th);
    int            ch[NCH];
    int            maxv = 2**CW - 1;
    int            q    = 2**(CW - POST_BITS);
    bit            is_edge = (e > th);
    logic [PW-1:0] r;
    if (mode == 2'd0) return pix;
    for (int c = 0; c < NCH; c++) ch[c] = int'(blur[c*CW +: CW]);
    case (mode)
      2'd1: begin
        if (is_edge) ch[0] = 0;
        else begin
          ch[1] = ch[1] * (2**SAT_SH) + SAT_OFS;
          if (ch[1] > maxv) ch[1] = maxv;
        end
      end
      2'd2: begin
        for (int c = 0; c < NCH; c++) ch[c] = 0;
        ch[0] = is_edge ? 0 : maxv;
      end
      default: begin
        for (int c = 0; c < NCH; c++) ch[c] = (ch[c] / q) * q;
        if (is_edge) ch[0] = 0;
      end
    endcase
    for (int c = 0; c < NCH; c++) r[c*CW +: CW] = CW'(ch[c]);
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      case (bp_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 99) < 60);
      endcase
    end
  end

  // Scoreboard sampled mid-cycle: predicts on input accepts, checks on output
  // accepts, and verifies that a stalled output holds its value.
  initial begin
    logic       prev_stall = 1'b0;
    exp_t       prev_out;
    exp_t       got;
    exp_t       want;
    logic [1:0] m;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        model_mode = 2'd0;
        prev_stall = 1'b0;
      end else begin
        got = '{sof: out_sof, side: out_side, pix: out_pixel};
        check("mode_active", 64'(mode_active), 64'(model_mode));
        if (prev_stall)
          check("stall_hold", {out_valid, got}, {1'b1, prev_out});
        if (out_valid && out_ready) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_output actual=%0h expected=none", got);
          end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
              errors++;
              $display("FAIL out_data actual=%0h expected=%0h", got, want);
            end
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = got;
        if (in_valid && in_ready) begin
          m = in_sof ? mode_req : model_mode;
          if (in_sof) model_mode = mode_req;
          exp_q.push_back('{sof: in_sof, side: in_side,
                            pix: ref_pix(m, in_pixel, in_blur, int'(in_edge), int'(edge_th))});
        end
      end
    end
  end

  task automatic send(input logic sof, input logic [1:0] mode, input logic [PW-1:0] pix,
                      input logic [PW-1:0] blur, input logic [CW-1:0] e, input logic [CW-1:0] th);
    int   n = 0;
    logic acc;
    in_valid = 1'b1;
    in_sof   = sof;
    mode_req = mode;
    in_pixel = pix;
    in_blur  = blur;
    in_edge  = e;
    edge_th  = th;
    in_side  = side_tag;
    side_tag = side_tag + 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 300);
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted");
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int n = 0;
    bp_mode = 1;
    while ((exp_q.size() != 0 || out_valid) && n < 500) begin
      idle(1);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  vec_t vecs[12];

  initial begin
    int start;
    vecs[0]  = '{2'd1, 24'h000000, 24'h403080, 8'h00, 8'h00, 24'h409280};
    vecs[1]  = '{2'd1, 24'h000000, 24'h40E080, 8'h00, 8'h00, 24'h40FF80};
    vecs[2]  = '{2'd1, 24'h000000, 24'h403080, 8'h10, 8'h0F, 24'h403000};
    vecs[3]  = '{2'd1, 24'h000000, 24'h403080, 8'h10, 8'h10, 24'h409280};
    vecs[4]  = '{2'd2, 24'h000000, 24'hFF9B57, 8'h00, 8'h00, 24'h0000FF};
    vecs[5]  = '{2'd3, 24'h000000, 24'hFF9B57, 8'h00, 8'h00, 24'hE08040};
    vecs[6]  = '{2'd0, 24'h123456, 24'hFF9B57, 8'hFF, 8'h00, 24'h123456};
    vecs[7]  = '{2'd2, 24'h000000, 24'h112233, 8'hFF, 8'hFF, 24'h0000FF};
    vecs[8]  = '{2'd2, 24'h000000, 24'h112233, 8'h80, 8'h7F, 24'h000000};
    vecs[9]  = '{2'd3, 24'h000000, 24'hFF9B57, 8'h80, 8'h7F, 24'hE08000};
    vecs[10] = '{2'd1, 24'h000000, 24'h0A660B, 8'h00, 8'h00, 24'h0AFE0B};
    vecs[11] = '{2'd1, 24'h000000, 24'h0A670B, 8'h00, 8'h00, 24'h0AFF0B};

    idle(3);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_mode", 64'(mode_active), 64'd0);
    check("rst_out_regs", {out_sof, out_side, out_pixel}, 64'd0);
    rst = 1'b0;
    idle(2);

    // Table: each vector starts a frame and is checked exactly two edges later.
    foreach (vecs[i]) begin
      send(1'b1, vecs[i].mode, vecs[i].pixel, vecs[i].blur, vecs[i].edg, vecs[i].th);
      idle(1);
      check($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("vec%0d_pixel", i), 64'(out_pixel), 64'(vecs[i].exp));
      check($sformatf("vec%0d_mode", i), 64'(mode_active), 64'(vecs[i].mode));
      idle(1);
    end

    // Mid-frame mode request is ignored until the next sof.
    send(1'b1, 2'd1, 24'h0, 24'h403080, 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) send(1'b0, 2'd2, 24'h0, 24'h405080 + 24'(i), 8'h00, 8'h00);
    check("midframe_mode", 64'(mode_active), 64'd1);
    send(1'b1, 2'd2, 24'h0, 24'h403080, 8'h00, 8'h00);
    send(1'b0, 2'd1, 24'h0, 24'h403080, 8'h20, 8'h10);
    drain();
    check("newframe_mode", 64'(mode_active), 64'd2);

    // sof presented during a stall latches only the mode present at accept.
    bp_mode = 0;
    idle(2);
    send(1'b1, 2'd1, 24'h0, 24'h112233, 8'h00, 8'h00);
    send(1'b0, 2'd3, 24'h0, 24'h445566, 8'h00, 8'h00);
    in_valid = 1'b1;
    in_sof   = 1'b1;
    mode_req = 2'd3;
    idle(3);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_no_latch", 64'(mode_active), 64'd1);
    bp_mode = 1;
    send(1'b1, 2'd2, 24'h0, 24'h778899, 8'h00, 8'h00);
    idle(1);
    check("stall_latch", 64'(mode_active), 64'd2);
    drain();

    // Back-to-back with out_ready high: one pixel per clock.
    start = cyc;
    for (int i = 0; i < 40; i++)
      send(i == 0, 2'(i % 4), PW'($urandom), PW'($urandom), CW'($urandom), CW'($urandom));
    check("throughput_cycles", 64'(cyc - start), 64'd40);
    drain();

    // Randomized traffic under random backpressure.
    bp_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      logic [CW-1:0] th;
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
      case ($urandom_range(0, 3))
        0:       th = 8'h00;
        1:       th = 8'hFF;
        default: th = CW'($urandom);
      endcase
      send($urandom_range(0, 15) == 0, 2'($urandom_range(0, 3)), PW'($urandom), PW'($urandom),
           CW'($urandom), th);
    end
    drain();

    // Reset with two pixels in flight discards them.
    bp_mode = 0;
    idle(2);
    send(1'b1, 2'd1, 24'h0, 24'hABCDEF, 8'h00, 8'h00);
    send(1'b0, 2'd1, 24'h0, 24'hFEDCBA, 8'h00, 8'h00);
    check("inflight_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    idle(1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_mode", 64'(mode_active), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd0);
    rst = 1'b0;
    bp_mode = 1;
    idle(10);
    check("postrst_no_output", 64'(out_valid), 64'd0);
    check("postrst_queue", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cartoon_pipe.md
Name: cartoon_pipe

Overview:
- Pipelined, stallable successor to the combinational cartoon stage in the video path between the blur/edge generators and the output formatter.
- Parametrised in channel width and channel count.
- Adds four selectable modes (bypass, cartoon, edge-only, posterize) and a programmable edge threshold.
- Mode changes are applied only at start-of-frame so a frame is never torn; sideband data is delayed in lockstep with pixels.

Parameters:
- CW, 8: bits per colour channel.
- NCH, 3: channels per pixel (>=2). Channel 0 = V at [CW-1:0], channel 1 = S, higher channels (H) are carried unmodified.
- SW, 24: sideband (pass-through) width.
- SAT_SH, 1: left-shift applied to S in cartoon mode.
- SAT_OFS, 50: offset added to the shifted S.
- POST_BITS, 3: MSBs kept per channel in posterize mode (1..CW).

Ports:
- clk  in  1  pixel clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input pixel valid
- in_ready  out  1  block can accept input
- in_sof  in  1  first pixel of frame
- in_pixel  in  NCH*CW  unfiltered pixel
- in_blur  in  NCH*CW  blurred pixel, aligned with in_pixel
- in_edge  in  CW  edge magnitude, aligned
- in_side  in  SW  sideband, delayed unchanged
- edge_th  in  CW  edge threshold; quasi-static, sampled per pixel
- mode_req  in  2  requested mode: 0 BYPASS, 1 CARTOON, 2 EDGE, 3 POSTER
- out_valid  out  1  output valid
- out_ready  in  1  downstream accept
- out_sof  out  1  delayed in_sof
- out_pixel  out  NCH*CW  result
- out_side  out  SW  delayed in_side
- mode_active  out  2  mode currently applied to accepted pixels

Behaviour:
- Transfer occurs on a clock edge with valid&&ready, on each side.
- Two register stages, S1 and S2. Latency is exactly 2 cycles with out_ready held high; full throughput of 1 pixel/clk.
- s2_load = !s2_valid || out_ready; in_ready = !s1_valid || s2_load (combinational; no other input-to-output combinational path).
- Stalled stages hold all data. Bubbles collapse.
- S1 captures in_pixel, in_blur, sideband, sof, and the per-pixel mode. It computes:
  - edge = (in_edge > edge_th)
  - sat_sum = ({S, SAT_SH zeros} + SAT_OFS), at width CW+SAT_SH+1
- S2 computes out_pixel from the S1 mode:
  - BYPASS: in_pixel unchanged.
  - CARTOON: in_blur. If !edge, S = min(sat_sum, 2^CW-1). If edge, V = 0.
  - EDGE: all channels 0, then V = edge ? 0 : 2^CW-1.
  - POSTER: each channel of in_blur with its low CW-POST_BITS bits cleared; then V = 0 if edge.
- Mode latching:
  - On accepting a pixel with in_sof=1, mode_active <= mode_req, and that pixel uses mode_req.
  - Non-sof pixels use the current mode_active.
  - mode_req changes mid-frame have no effect until the next sof.
  - Each pixel carries its own mode, so in-flight pixels finish in their original mode.
- Reset: s1_valid = s2_valid = 0, out_valid = 0, mode_active = BYPASS. While rst is high, in_ready = 0. Data registers need no reset; out_pixel, out_side, and out_sof read 0 after reset (registers cleared). Reset mid-frame discards in-flight pixels.
- Boundaries:
  - edge == edge_th counts as non-edge.
  - edge_th = 2^CW-1 means never an edge.
  - The saturating add clamps exactly at 2^CW-1; there is no wrap.
  - sof and mode change in the same cycle as a stall: the latch happens only on the actual accept.
  - out_valid must not drop while out_ready is low.

Decomposition:
- Package cartoon_pkg holds:
  - mode encodings: MODE_BYPASS=0, MODE_CARTOON=1, MODE_EDGE=2, MODE_POSTER=3
  - channel index constants: CH_V=0, CH_S=1
- One sub-module, sat_add_shift (parameters CW, SH, OFS): shift-add-clamp, combinational, used in S1.
- The two-stage valid/ready skeleton stays inline.

Test Plan:
- Reset, then CARTOON at sof with in_blur=0x40_30_80, in_edge=0, edge_th=0 -> out_pixel=0x40_92_80 (0x30<<1+50=146) two cycles later. mode_active=1.
- Same setup, S=0xE0 -> S clamped to 0xFF. in_edge=0x10, edge_th=0x0F -> V=0x00, S unchanged. edge_th=0x10 -> treated as non-edge.
- EDGE and POSTER with POST_BITS=3, blur=0xFF_9B_57, edge=0 -> EDGE gives 0x00_00_FF; POSTER gives 0xE0_80_40.
- Raise mode_req to EDGE mid-frame -> pixels stay CARTOON until the next sof; the sof pixel and all later ones are EDGE. Sideband matches each pixel.
- Random out_ready backpressure over 1000 pixels -> no loss, no duplication, order preserved, out_valid stable while stalled, throughput 1/clk when out_ready=1.
- Assert rst with two pixels in flight -> out_valid=0 on the next cycle, mode_active=BYPASS, no stale pixel emitted after rst deasserts.
